// File: rtl/sort_if.sv
// Handshake and data bundle between the input stage, the sort engine and
// the display/output stage.
interface sort_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic [WIDTH-1:0] unsorted_num0;
    logic [WIDTH-1:0] unsorted_num1;
    logic [WIDTH-1:0] unsorted_num2;
    logic [WIDTH-1:0] unsorted_num3;
    logic [WIDTH-1:0] sorted_num0;
    logic [WIDTH-1:0] sorted_num1;
    logic [WIDTH-1:0] sorted_num2;
    logic [WIDTH-1:0] sorted_num3;
    logic             busy;
    logic             done;
    logic [2:0]       swap_count;

    // Side that requests sorts and consumes results.
    modport master (
        output start,
        output unsorted_num0, unsorted_num1, unsorted_num2, unsorted_num3,
        input  sorted_num0, sorted_num1, sorted_num2, sorted_num3,
        input  busy, done, swap_count
    );

    // The sort engine itself.
    modport slave (
        input  start,
        input  unsorted_num0, unsorted_num1, unsorted_num2, unsorted_num3,
        output sorted_num0, sorted_num1, sorted_num2, sorted_num3,
        output busy, done, swap_count
    );
endinterface

// File: rtl/sort_engine.sv
// Four-element sequential bubble sort: captures the inputs on start, runs
// six fixed compare/swap steps (one per clock), then publishes the result
// with a one-cycle done pulse. The published result is held while a new
// sort is in flight.
module sort_engine #(
    parameter int WIDTH      = 4,
    parameter bit DESCENDING = 1'b0
) (
    input logic  clk,
    input logic  rst,
    sort_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] w0, w1, w2, w3;
    logic [2:0]       step;
    logic [2:0]       count;

    logic [WIDTH-1:0] pair_a;
    logic [WIDTH-1:0] pair_b;
    logic             swap;

    // True when the pair (a,b) is out of order for the selected direction;
    // equal values are never considered out of order.
    function automatic logic out_of_order(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
        if (DESCENDING)
            return (a < b);
        else
            return (a > b);
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic: start is only honoured from IDLE, so requests made
    // while busy are dropped rather than queued.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.start) next_state = SORT;
            SORT: if (step >= 3'd5) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: busy covers both SORT and DONE, so it has already fallen
    // in the cycle where done is visible.
    always_comb begin
        bus.busy = (state != IDLE);
    end

    // Pair selection for the current step; unreachable steps 6..7 behave as
    // step 5 so the network can never touch a wrong pair.
    always_comb begin
        pair_a = w0;
        pair_b = w1;
        case (step)
            3'd0: begin pair_a = w0; pair_b = w1; end
            3'd1: begin pair_a = w1; pair_b = w2; end
            3'd2: begin pair_a = w2; pair_b = w3; end
            3'd3: begin pair_a = w0; pair_b = w1; end
            3'd4: begin pair_a = w1; pair_b = w2; end
            default: begin pair_a = w0; pair_b = w1; end
        endcase
        swap = out_of_order(pair_a, pair_b);
    end

    // Working registers, step index and swap counter: loaded on an accepted
    // start, updated one compare/swap per clock during SORT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w0    <= '0;
            w1    <= '0;
            w2    <= '0;
            w3    <= '0;
            step  <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        w0    <= bus.unsorted_num0;
                        w1    <= bus.unsorted_num1;
                        w2    <= bus.unsorted_num2;
                        w3    <= bus.unsorted_num3;
                        step  <= '0;
                        count <= '0;
                    end
                end
                SORT: begin
                    if (swap) begin
                        case (step)
                            3'd1, 3'd4: begin w1 <= w2; w2 <= w1; end
                            3'd2:       begin w2 <= w3; w3 <= w2; end
                            default:    begin w0 <= w1; w1 <= w0; end
                        endcase
                        // At most six swaps fit in six steps, so 3 bits
                        // cannot overflow.
                        count <= count + 3'd1;
                    end
                    if (step < 3'd5)
                        step <= step + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Result registers and done pulse: updated only on the DONE edge so the
    // downstream stage sees a stable result during the next sort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sorted_num0 <= '0;
            bus.sorted_num1 <= '0;
            bus.sorted_num2 <= '0;
            bus.sorted_num3 <= '0;
            bus.swap_count  <= '0;
            bus.done        <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == DONE) begin
                bus.sorted_num0 <= w0;
                bus.sorted_num1 <= w1;
                bus.sorted_num2 <= w2;
                bus.sorted_num3 <= w3;
                bus.swap_count  <= count;
                bus.done        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sort_engine.sv
// Self-checking bench for sort_engine: an ascending and a descending
// instance are driven in lockstep and compared against a reference model.
module tb_sort_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sort_if #(.WIDTH(4)) asc_if ();
    sort_if #(.WIDTH(4)) dsc_if ();

    sort_engine #(.WIDTH(4), .DESCENDING(1'b0)) dut_asc (
        .clk (clk),
        .rst (rst),
        .bus (asc_if.slave)
    );

    sort_engine #(.WIDTH(4), .DESCENDING(1'b1)) dut_dsc (
        .clk (clk),
        .rst (rst),
        .bus (dsc_if.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] last_asc = '0;

    // Reference: final order is defined purely by value, so any sort will do.
    function automatic logic [15:0] model_sorted(input logic [15:0] v, input bit desc);
        int e[4];
        int t;
        logic [15:0] r;
        for (int i = 0; i < 4; i++) e[i] = int'(v[i*4 +: 4]);
        for (int p = 0; p < 3; p++)
            for (int q = p + 1; q < 4; q++)
                if (desc ? (e[q] > e[p]) : (e[q] < e[p])) begin
                    t = e[p]; e[p] = e[q]; e[q] = t;
                end
        for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'(e[i]);
        return r;
    endfunction

    // A complete bubble sort performs exactly one swap per strict inversion.
    function automatic logic [2:0] model_swaps(input logic [15:0] v, input bit desc);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (desc ? (v[i*4 +: 4] < v[j*4 +: 4]) : (v[i*4 +: 4] > v[j*4 +: 4]))
                    n++;
        return 3'(n);
    endfunction

    function automatic logic [15:0] asc_result();
        return {asc_if.sorted_num3, asc_if.sorted_num2, asc_if.sorted_num1, asc_if.sorted_num0};
    endfunction

    function automatic logic [15:0] dsc_result();
        return {dsc_if.sorted_num3, dsc_if.sorted_num2, dsc_if.sorted_num1, dsc_if.sorted_num0};
    endfunction

    task automatic set_in(input logic [15:0] v, input logic s);
        asc_if.unsorted_num0 = v[3:0];
        asc_if.unsorted_num1 = v[7:4];
        asc_if.unsorted_num2 = v[11:8];
        asc_if.unsorted_num3 = v[15:12];
        asc_if.start         = s;
        dsc_if.unsorted_num0 = v[3:0];
        dsc_if.unsorted_num1 = v[7:4];
        dsc_if.unsorted_num2 = v[11:8];
        dsc_if.unsorted_num3 = v[15:12];
        dsc_if.start         = s;
    endtask

    // Presents v with start for exactly one rising edge (E0); returns #1 after E0.
    task automatic drive_start(input logic [15:0] v);
        @(negedge clk);
        set_in(v, 1'b1);
        @(posedge clk);
        #1;
        set_in(v, 1'b0);
    endtask

    // Counts edges until done is seen; -1 if it never arrives within budget.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (asc_if.done === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        set_in(16'h0000, 1'b0);
        rst = 1'b1;
        #12;
        checks++;
        if (asc_result() !== 16'h0000) begin
            errors++; $display("FAIL reset_result got %h exp 0000", asc_result());
        end
        checks++;
        if (asc_if.swap_count !== 3'd0) begin
            errors++; $display("FAIL reset_swaps got %0d exp 0", asc_if.swap_count);
        end
        checks++;
        if (asc_if.busy !== 1'b0 || asc_if.done !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl got busy=%b done=%b exp 0 0", asc_if.busy, asc_if.done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (asc_if.busy !== 1'b0 || asc_if.done !== 1'b0) begin
            errors++; $display("FAIL idle_ctrl got busy=%b done=%b exp 0 0", asc_if.busy, asc_if.done);
        end
    endtask

    task automatic test_directed();
        logic [15:0] vin  [4] = '{16'h1739, 16'h4321, 16'h05AF, 16'h4244};
        logic [15:0] vexp [4] = '{16'h9731, 16'h4321, 16'hFA50, 16'h4442};
        logic [2:0]  sexp [4] = '{3'd5, 3'd0, 3'd6, 3'd2};
        int early_done;
        int unstable;
        for (int ii = 0; ii < 4; ii++) begin
            drive_start(vin[ii]);
            checks++;
            if (asc_if.busy !== 1'b1) begin
                errors++; $display("FAIL dir_busy_start[%0d] got %b exp 1", ii, asc_if.busy);
            end
            early_done = 0;
            unstable = 0;
            for (int k = 1; k <= 7; k++) begin
                @(posedge clk);
                #1;
                if (k < 7) begin
                    if (asc_if.done !== 1'b0) early_done++;
                    if (asc_result() !== last_asc || asc_if.busy !== 1'b1) unstable++;
                end
            end
            checks++;
            if (early_done != 0 || unstable != 0) begin
                errors++; $display("FAIL dir_during[%0d] got early_done=%0d unstable=%0d exp 0 0", ii, early_done, unstable);
            end
            checks++;
            if (asc_if.done !== 1'b1 || asc_if.busy !== 1'b0) begin
                errors++; $display("FAIL dir_done[%0d] got done=%b busy=%b exp 1 0", ii, asc_if.done, asc_if.busy);
            end
            checks++;
            if (asc_result() !== vexp[ii] || asc_if.swap_count !== sexp[ii]) begin
                errors++; $display("FAIL dir_result[%0d] got %h/%0d exp %h/%0d", ii, asc_result(), asc_if.swap_count, vexp[ii], sexp[ii]);
            end
            if (ii == 0) begin
                checks++;
                if (dsc_result() !== 16'h1379) begin
                    errors++; $display("FAIL dir_desc got %h exp 1379", dsc_result());
                end
            end
            last_asc = asc_result();
            @(posedge clk);
            #1;
            checks++;
            if (asc_if.done !== 1'b0) begin
                errors++; $display("FAIL dir_pulse[%0d] got done=%b exp 0", ii, asc_if.done);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        int cyc;
        for (int n = 0; n < 25; n++) begin
            v = 16'($urandom);
            drive_start(v);
            wait_done(cyc);
            checks++;
            if (cyc != 7) begin
                errors++; $display("FAIL rnd_latency[%0d] got %0d exp 7", n, cyc);
            end
            checks++;
            if (asc_result() !== model_sorted(v, 1'b0) || asc_if.swap_count !== model_swaps(v, 1'b0)) begin
                errors++; $display("FAIL rnd_asc[%0d] in %h got %h/%0d exp %h/%0d", n, v, asc_result(), asc_if.swap_count, model_sorted(v, 1'b0), model_swaps(v, 1'b0));
            end
            checks++;
            if (dsc_result() !== model_sorted(v, 1'b1) || dsc_if.swap_count !== model_swaps(v, 1'b1)) begin
                errors++; $display("FAIL rnd_dsc[%0d] in %h got %h/%0d exp %h/%0d", n, v, dsc_result(), dsc_if.swap_count, model_sorted(v, 1'b1), model_swaps(v, 1'b1));
            end
            last_asc = asc_result();
        end
    endtask

    task automatic test_start_while_busy();
        logic [15:0] va = 16'h1739;
        logic [15:0] vb = 16'h05AF;
        int ndone;
        int first;
        logic busy6;
        logic busy7;
        drive_start(va);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        set_in(vb, 1'b1);
        @(posedge clk);
        #1;
        set_in(vb, 1'b0);
        ndone = 0;
        first = -1;
        busy6 = 1'b0;
        busy7 = 1'b1;
        for (int k = 4; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (asc_if.done === 1'b1) begin
                ndone++;
                if (first < 0) first = k;
            end
            if (k == 6) busy6 = asc_if.busy;
            if (k == 7) busy7 = asc_if.busy;
        end
        checks++;
        if (ndone != 1 || first != 7) begin
            errors++; $display("FAIL busy_start_done got count=%0d at=%0d exp 1 at 7", ndone, first);
        end
        checks++;
        if (busy6 !== 1'b1 || busy7 !== 1'b0) begin
            errors++; $display("FAIL busy_start_busy got e6=%b e7=%b exp 1 0", busy6, busy7);
        end
        checks++;
        if (asc_result() !== model_sorted(va, 1'b0)) begin
            errors++; $display("FAIL busy_start_result got %h exp %h", asc_result(), model_sorted(va, 1'b0));
        end
        last_asc = asc_result();
    endtask

    task automatic test_back_to_back();
        logic [15:0] va = 16'h2C8E;
        logic [15:0] vb = 16'h7F13;
        int cyc;
        drive_start(va);
        wait_done(cyc);
        checks++;
        if (cyc != 7 || asc_result() !== model_sorted(va, 1'b0)) begin
            errors++; $display("FAIL b2b_first got lat=%0d res=%h exp 7 %h", cyc, asc_result(), model_sorted(va, 1'b0));
        end
        set_in(vb, 1'b1);
        @(posedge clk);
        #1;
        set_in(vb, 1'b0);
        checks++;
        if (asc_if.busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept got busy=%b exp 1", asc_if.busy);
        end
        wait_done(cyc);
        checks++;
        if (cyc != 7 || asc_result() !== model_sorted(vb, 1'b0) || asc_if.swap_count !== model_swaps(vb, 1'b0)) begin
            errors++; $display("FAIL b2b_second got lat=%0d res=%h/%0d exp 7 %h/%0d", cyc, asc_result(), asc_if.swap_count, model_sorted(vb, 1'b0), model_swaps(vb, 1'b0));
        end
        last_asc = asc_result();
    endtask

    task automatic test_async_reset();
        logic [15:0] v1 = 16'h5E29;
        logic [15:0] v2 = 16'hB36D;
        int ndone;
        int cyc;
        drive_start(v1);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (asc_result() !== 16'h0000 || asc_if.swap_count !== 3'd0) begin
            errors++; $display("FAIL areset_result got %h/%0d exp 0000/0", asc_result(), asc_if.swap_count);
        end
        checks++;
        if (asc_if.busy !== 1'b0 || asc_if.done !== 1'b0) begin
            errors++; $display("FAIL areset_ctrl got busy=%b done=%b exp 0 0", asc_if.busy, asc_if.done);
        end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (asc_if.done !== 1'b0 || asc_if.busy !== 1'b0) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++; $display("FAIL areset_quiet got active_cycles=%0d exp 0", ndone);
        end
        drive_start(v2);
        wait_done(cyc);
        checks++;
        if (cyc != 7 || asc_result() !== model_sorted(v2, 1'b0)) begin
            errors++; $display("FAIL areset_resort got lat=%0d res=%h exp 7 %h", cyc, asc_result(), model_sorted(v2, 1'b0));
        end
        last_asc = asc_result();
    endtask

    task automatic test_isolation();
        logic [15:0] v = 16'h9D04;
        drive_start(v);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            set_in(16'($urandom), 1'b0);
            @(posedge clk);
            #1;
        end
        checks++;
        if (asc_if.done !== 1'b1 || asc_result() !== model_sorted(v, 1'b0) || asc_if.swap_count !== model_swaps(v, 1'b0)) begin
            errors++; $display("FAIL isolation got done=%b res=%h/%0d exp 1 %h/%0d", asc_if.done, asc_result(), asc_if.swap_count, model_sorted(v, 1'b0), model_swaps(v, 1'b0));
        end
        checks++;
        if (dsc_result() !== model_sorted(v, 1'b1)) begin
            errors++; $display("FAIL isolation_desc got %h exp %h", dsc_result(), model_sorted(v, 1'b1));
        end
        last_asc = asc_result();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_async_reset();
        test_isolation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
